// File: rtl/shift_sequencer_pkg.sv
// ============================================================================
// Module   : shift_sequencer_pkg
// Purpose  : Shared shift opcodes, sequencer state encoding and default width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_sequencer_pkg;

   localparam int ALU_WIDTH = 16;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_SHL = 3'b001;
   localparam logic [2:0] OP_SHR = 3'b010;
   localparam logic [2:0] OP_ASR = 3'b011;
   localparam logic [2:0] OP_RCL = 3'b100;
   localparam logic [2:0] OP_RCR = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_shift_op(input logic [2:0] op);
      return (op >= OP_SHL) && (op <= OP_RCR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-position shift/rotate with carry and overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic             ci,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] o,
   output logic             c,
   output logic             v
);

   always_comb begin
      o = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_SHL: begin
            o = {a[WIDTH-2:0], 1'b0};
            c = a[WIDTH-1];
            v = a[WIDTH-1] ^ a[WIDTH-2];
         end
         OP_SHR: begin
            o = {1'b0, a[WIDTH-1:1]};
            c = a[0];
            v = a[WIDTH-1];
         end
         OP_ASR: begin
            // All-ones operand collapses to zero rather than staying at -1
            o = (a == '1) ? '0 : {a[WIDTH-1], a[WIDTH-1:1]};
            c = a[0];
         end
         OP_RCL: begin
            o = {a[WIDTH-2:0], ci};
            c = a[WIDTH-1];
            v = a[WIDTH-1] ^ a[WIDTH-2];
         end
         OP_RCR: begin
            o = {ci, a[WIDTH-1:1]};
            c = a[0];
            v = a[WIDTH-1] ^ ci;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Iterates shift_step one position per clock for multi-bit shifts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] abus,
   input  logic [CNT_W-1:0] amount,
   input  logic             cin,
   output logic [WIDTH-1:0] outbus,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_acc;
   logic               r_carry;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_opr;

   logic [WIDTH-1:0]   w_step_o;
   logic               w_step_c;
   logic               w_step_v;
   logic               w_op_valid;
   logic               w_to_shift;

   assign w_op_valid = is_shift_op(op);
   assign w_to_shift = w_op_valid && (amount != '0);

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .a  (r_acc),
      .ci (r_carry),
      .op (r_opr),
      .o  (w_step_o),
      .c  (w_step_c),
      .v  (w_step_v)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = w_to_shift ? SHIFT : DONE;
         SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
         r_opr   <= OP_NOP;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  // Non-shift opcodes yield zero; a zero amount passes abus through
                  r_opr   <= op;
                  r_ovf   <= 1'b0;
                  r_acc   <= w_op_valid ? abus : '0;
                  r_carry <= w_to_shift ? cin : 1'b0;
                  r_cnt   <= w_to_shift ? amount : '0;
               end
            end
            SHIFT: begin
               r_acc   <= w_step_o;
               r_carry <= w_step_c;
               r_ovf   <= r_ovf | w_step_v;
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign outbus   = r_acc;
   assign cout     = r_carry;
   assign overflow = r_ovf;
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Directed self-checking bench for shift_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [15:0] abus;
   logic [3:0]  amount;
   logic        cin;
   logic [15:0] outbus;
   logic        cout;
   logic        overflow;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   shift_sequencer #(
      .WIDTH (16),
      .CNT_W (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .abus     (abus),
      .amount   (amount),
      .cin      (cin),
      .outbus   (outbus),
      .cout     (cout),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int exp_lat, input int k0);
      int k = k0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " latency"}, 32'(k), 32'(exp_lat));
   endtask

   task automatic run_op(input string tag, input logic [2:0] o_op, input logic [15:0] a,
                         input logic [3:0] amt, input logic ci, input logic [15:0] exp_o,
                         input logic exp_c, input logic exp_v, input int exp_lat);
      op = o_op; abus = a; amount = amt; cin = ci; start = 1'b1;
      tick();
      start = 1'b0;
      // Scramble inputs to show only the captured values matter
      op = ~o_op; abus = ~a; amount = ~amt; cin = ~ci;
      if (exp_lat > 1) chk({tag, " busy"}, 32'(busy), 32'd1);
      wait_done(tag, exp_lat, 1);
      chk({tag, " outbus"}, 32'(outbus), 32'(exp_o));
      chk({tag, " cout"}, 32'(cout), 32'(exp_c));
      chk({tag, " overflow"}, 32'(overflow), 32'(exp_v));
      tick();
      chk({tag, " done pulse"}, 32'(done), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
      chk({tag, " hold"}, 32'(outbus), 32'(exp_o));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'b000; abus = 16'h0; amount = 4'h0; cin = 1'b0;
      repeat (3) tick();
      chk("rst outbus", 32'(outbus), 32'h0);
      chk("rst cout", 32'(cout), 32'd0);
      chk("rst overflow", 32'(overflow), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      reset = 1'b0;
      tick();

      run_op("shl1",  3'b001, 16'h4001, 4'd1,  1'b0, 16'h8002, 1'b0, 1'b1, 2);
      run_op("shr4",  3'b010, 16'h8001, 4'd4,  1'b0, 16'h0800, 1'b0, 1'b1, 5);
      run_op("asr3",  3'b011, 16'h8000, 4'd3,  1'b0, 16'hF000, 1'b0, 1'b0, 4);
      run_op("asrff", 3'b011, 16'hFFFF, 4'd1,  1'b0, 16'h0000, 1'b1, 1'b0, 2);
      run_op("rcl2",  3'b100, 16'h8000, 4'd2,  1'b0, 16'h0001, 1'b0, 1'b1, 3);
      run_op("rcr2",  3'b101, 16'h0001, 4'd2,  1'b1, 16'hC000, 1'b0, 1'b1, 3);
      run_op("amt0",  3'b001, 16'h1234, 4'd0,  1'b1, 16'h1234, 1'b0, 1'b0, 1);
      run_op("shl15", 3'b001, 16'h0001, 4'd15, 1'b0, 16'h8000, 1'b0, 1'b1, 16);
      run_op("op110", 3'b110, 16'h1234, 4'd3,  1'b1, 16'h0000, 1'b0, 1'b0, 1);
      run_op("op000", 3'b000, 16'hFFFF, 4'd2,  1'b1, 16'h0000, 1'b0, 1'b0, 1);

      // Start pulsed while busy with different operands must be ignored
      op = 3'b010; abus = 16'h8001; amount = 4'd4; cin = 1'b0; start = 1'b1;
      tick();
      op = 3'b001; abus = 16'hFFFF; amount = 4'd1; cin = 1'b1;
      tick();
      tick();
      start = 1'b0;
      wait_done("ignore", 5, 3);
      chk("ignore outbus", 32'(outbus), 32'h0800);
      chk("ignore cout", 32'(cout), 32'd0);
      chk("ignore overflow", 32'(overflow), 32'd1);
      tick();

      // Reset on the third SHIFT cycle aborts the operation
      op = 3'b001; abus = 16'h00FF; amount = 4'd8; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("midrst busy before", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst outbus", 32'(outbus), 32'h0);
      chk("midrst cout", 32'(cout), 32'd0);
      chk("midrst overflow", 32'(overflow), 32'd0);

      // Reset wins over a simultaneous start
      op = 3'b001; abus = 16'h4001; amount = 4'd1; start = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      chk("rst+start busy", 32'(busy), 32'd0);
      chk("rst+start outbus", 32'(outbus), 32'h0);
      tick();

      run_op("fresh", 3'b001, 16'h4001, 4'd1, 1'b0, 16'h8002, 1'b0, 1'b1, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
